// File: rtl/bin2bcd8.sv
// bin2bcd8: 27-bit unsigned binary to 8-digit packed BCD converter.
// Sequential double-dabble: one shift per clock, 27 shifts, then a
// one-cycle DONE state that publishes the low 8 digits and the overflow flag.
// Build option: BIN2BCD_SAT_EN -- when defined, an overflowing result
// (value > 99,999,999) is shown as 9999_9999 instead of the wrapped low digits.
module bin2bcd8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [26:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [31:0] bcd_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [26:0] bin_sr;    // binary operand, consumed MSB first
    logic [35:0] acc;       // 9-digit BCD accumulator
    logic [34:0] acc_adj;   // accumulator after add-3 correction, pre-shift
    logic [4:0]  cnt;       // remaining iterations; 0 marks the last one

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic; start is only honoured from IDLE, never queued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction on digits 0..7; digit 8 never exceeds 1 for a 27-bit
    // input, so it is passed through and its top bit falls off in the shift
    always_comb begin
        acc_adj = acc[34:0];
        for (int d = 0; d < 8; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    // shift datapath: load on accepted start, one dabble step per SHIFT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        acc    <= '0;
                        cnt    <= 5'd26;
                    end
                end
                SHIFT: begin
                    acc    <= {acc_adj, bin_sr[26]};
                    bin_sr <= {bin_sr[25:0], 1'b0};
                    cnt    <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // registered outputs; busy lags the state by one cycle so it covers the
    // done pulse and drops on the cycle a new start can be accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd_out <= '0;
        end else begin
            busy <= (state != IDLE);
            done <= (state == DONE);
            if (state == DONE) begin
                ovf <= (acc[35:32] != 4'd0);
`ifdef BIN2BCD_SAT_EN
                if (acc[35:32] != 4'd0) bcd_out <= 32'h9999_9999;
                else                    bcd_out <= acc[31:0];
`else
                bcd_out <= acc[31:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd8.sv
// Self-checking bench for bin2bcd8: directed cases, abort-by-reset,
// ignored starts, and a long back-to-back random run against an
// arithmetic (divide/modulo) reference model.
module tb_bin2bcd8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [26:0] bin_in;
    logic        busy, done, ovf;
    logic [31:0] bcd_out;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;

    bin2bcd8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // free-running edge counter for done-spacing checks
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0]  r;
        int unsigned  x;
        r = '0;
`ifdef BIN2BCD_SAT_EN
        if (v > 99_999_999) return 32'h9999_9999;
`endif
        x = v % 100_000_000;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned v);
        return (v > 99_999_999) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] nib_ok(input logic [31:0] b);
        for (int d = 0; d < 8; d++)
            if (b[4*d +: 4] > 4'd9) return 32'd0;
        return 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One conversion; optionally inject a start pulse with another value
    // so it is sampled at edge N+inj_at+1 (must be ignored).
    task automatic run_conv(input int unsigned v, input int inj_at,
                            input int unsigned inj_v, input string tag);
        int lat, bcnt;
        logic [31:0] exp_bcd;
        lat = 0; bcnt = 0;
        exp_bcd = ref_bcd(v);
        @(negedge clk); start = 1'b1; bin_in = 27'(v);
        @(negedge clk); start = 1'b0; bin_in = 27'($urandom);
        chk({tag, " busy_after_start_edge"}, 32'(busy), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == inj_at) begin start = 1'b1; bin_in = 27'(inj_v); end
            if (busy) bcnt++;
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd28);
        chk({tag, " busy_cycles"}, 32'(bcnt), 32'd28);
        chk({tag, " bcd_out"}, bcd_out, exp_bcd);
        chk({tag, " ovf"}, 32'(ovf), ref_ovf(v));
        chk({tag, " nibbles"}, nib_ok(bcd_out), 32'd1);
        @(posedge clk); #1;
        chk({tag, " busy_drop"}, 32'(busy), 32'd0);
        chk({tag, " done_pulse_one"}, 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " no_requeue"}, 32'(busy), 32'd0);
        chk({tag, " bcd_hold"}, bcd_out, exp_bcd);
    endtask

    int unsigned vals[1002];

    initial begin
        int ndone, t_last;
        bit got;

        reset_n = 1'b0; start = 1'b0; bin_in = '0;
        #5;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset bcd_out", bcd_out, 32'h0);
        @(negedge clk); reset_n = 1'b1;

        // directed conversions
        run_conv(0,           0, 0, "zero");
        run_conv(12_345_678,  0, 0, "12345678");
        run_conv(99_999_999,  0, 0, "max_in_range");
        run_conv(134_217_727, 0, 0, "full_scale");
        run_conv(100_000_000, 0, 0, "first_ovf");
        run_conv(87_654_321,  9, 55_555_555, "ignore_start_mid");
        run_conv(13_579_246,  27, 1_111_111, "ignore_start_done");

        // reset 15 cycles into a conversion
        @(negedge clk); start = 1'b1; bin_in = 27'd2_468_013;
        @(negedge clk); start = 1'b0;
        repeat (15) @(posedge clk);
        #1; reset_n = 1'b0; #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort ovf", 32'(ovf), 32'd0);
        chk("abort bcd_out", bcd_out, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort no_done_after", 32'(ndone), 32'd0);
        run_conv(76_543_210, 0, 0, "after_abort");

        // back-to-back with start held high
        foreach (vals[i]) begin
            case ($urandom_range(0, 9))
                0:       vals[i] = 0;
                1:       vals[i] = 99_999_999;
                2:       vals[i] = 100_000_000;
                3:       vals[i] = 134_217_727;
                default: vals[i] = $urandom_range(0, 134_217_727);
            endcase
        end
        @(negedge clk); start = 1'b1; bin_in = 27'(vals[0]);
        @(posedge clk);
        @(negedge clk); bin_in = 27'(vals[1]);
        t_last = 0;
        for (int i = 0; i < 1000; i++) begin
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) begin got = 1'b1; break; end
            end
            chk("b2b done_seen", 32'(got), 32'd1);
            if (!got) break;
            chk("b2b bcd_out", bcd_out, ref_bcd(vals[i]));
            chk("b2b ovf", 32'(ovf), ref_ovf(vals[i]));
            chk("b2b nibbles", nib_ok(bcd_out), 32'd1);
            if (i > 0) chk("b2b spacing", 32'(edge_cnt - t_last), 32'd29);
            t_last = edge_cnt;
            if (fails > 10) break;
            @(posedge clk);
            @(negedge clk); bin_in = 27'(vals[i+2]);
        end
        start = 1'b0;
        repeat (35) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
